// File: rtl/ah_weighted_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : ah_weighted_rr_arbiter                                           |
// | Brief    : Credit-weighted round-robin arbiter with registered one-hot grant |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module ah_weighted_rr_arbiter #(
  parameter int N  = 8,
  parameter int WW = 6,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] cfg_weight,
  input  logic            cfg_load,
  input  logic            ack,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_id
);

  localparam logic [IW:0] c_n = (IW+1)'(N);

  logic [WW-1:0] w_weight      [N];
  logic [WW-1:0] w_credit_post [N];
  logic [WW-1:0] r_credit      [N];

  logic [N-1:0]  w_wgt_nz;
  logic [N-1:0]  w_dec;
  logic [N-1:0]  w_post_nz;
  logic [N-1:0]  w_elig_post;
  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_rot;
  logic [N-1:0]  w_win_onehot;
  logic          w_arb;
  logic          w_accept;
  logic          w_exhaust;
  logic          w_refresh;
  logic          w_found;
  logic          w_hold;
  logic [IW-1:0] w_ptr_next;
  logic [IW-1:0] w_off;
  logic [IW-1:0] w_win_id;
  logic [IW:0]   w_sum;

  logic [N-1:0]  r_grant;
  logic          r_grant_valid;
  logic [IW-1:0] r_grant_id;
  logic [IW-1:0] r_ptr;

  assign w_arb    = ~r_grant_valid | ack;
  assign w_accept = r_grant_valid & ack;
  assign w_hold   = |(req & r_grant);

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      assign w_weight[i]    = cfg_weight[i*WW +: WW];
      assign w_wgt_nz[i]    = |w_weight[i];
      assign w_dec[i]       = w_accept & r_grant[i];
      // Saturating charge for the requester being acknowledged this cycle.
      assign w_credit_post[i] = (w_dec[i] && (|r_credit[i])) ? r_credit[i] - WW'(1) : r_credit[i];
      assign w_post_nz[i]   = |w_credit_post[i];
      assign w_elig_post[i] = req[i] & w_post_nz[i];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_credit[i] <= '0;
        end else if (cfg_load || w_refresh) begin
          r_credit[i] <= w_weight[i];
        end else begin
          r_credit[i] <= w_credit_post[i];
        end
      end
    end
  endgenerate

  assign w_exhaust = |(w_dec & ~w_post_nz);

  // Pointer as it will be after this cycle's ack; the search already uses it.
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_accept) begin
      if (w_exhaust) begin
        w_ptr_next = (r_grant_id == IW'(N-1)) ? '0 : r_grant_id + IW'(1);
      end else begin
        w_ptr_next = r_grant_id;
      end
    end
  end

  // Zero-weight requesters never count toward the refresh condition.
  assign w_refresh = w_arb & (|(req & w_wgt_nz)) & ~(|w_elig_post);
  assign w_elig    = w_refresh ? (req & w_wgt_nz) : w_elig_post;
  assign w_found   = |w_elig;

  assign w_rot = N'({w_elig, w_elig} >> w_ptr_next);

  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
  end

  assign w_sum        = {1'b0, w_ptr_next} + {1'b0, w_off};
  assign w_win_id     = (w_sum >= c_n) ? IW'(w_sum - c_n) : IW'(w_sum);
  assign w_win_onehot = N'(1) << w_win_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_ptr         <= '0;
    end else begin
      r_ptr <= w_ptr_next;
      if (w_arb) begin
        r_grant       <= w_found ? w_win_onehot : '0;
        r_grant_valid <= w_found;
        r_grant_id    <= w_found ? w_win_id : '0;
      end else if (!w_hold) begin
        r_grant       <= '0;
        r_grant_valid <= 1'b0;
        r_grant_id    <= '0;
      end
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_ah_weighted_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_ah_weighted_rr_arbiter                                        |
// | Brief    : Directed vector bench for ah_weighted_rr_arbiter (N=4, WW=4)      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_ah_weighted_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] cfg_weight;
  logic        cfg_load;
  logic        ack;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  ah_weighted_rr_arbiter #(.N(4), .WW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .cfg_weight  (cfg_weight),
    .cfg_load    (cfg_load),
    .ack         (ack),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [15:0] wgt;
    bit          load;
    bit          ack;
    logic [3:0]  eg;
    logic [1:0]  eid;
  } vec_t;

  vec_t vecs[$];

  function void add(input bit rst, input logic [3:0] rq, input logic [15:0] w,
                    input bit ld, input bit ak, input logic [3:0] eg, input logic [1:0] eid);
    vec_t v;
    v.rst = rst; v.req = rq; v.wgt = w; v.load = ld; v.ack = ak; v.eg = eg; v.eid = eid;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] eid);
    check({tag, " grant"},       32'(grant),       32'(eg));
    check({tag, " grant_valid"}, 32'(grant_valid), 32'(|eg));
    check({tag, " grant_id"},    32'(grant_id),    32'(eid));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; ack = 1'b0; cfg_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] seq_g [5];
    logic [1:0] seq_id [5];

    rst_n = 1'b0; req = '0; cfg_weight = '0; cfg_load = 1'b0; ack = 1'b0;

    // Weights {3,1,2,1}: 0,0,0,1,2,2,3 then refresh without a bubble
    add(1, 4'b1111, 16'h1213, 0, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 16'h1213, 0, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 16'h1213, 0, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 16'h1213, 0, 1, 4'b0010, 2'd1);
    add(0, 4'b1111, 16'h1213, 0, 1, 4'b0100, 2'd2);
    add(0, 4'b1111, 16'h1213, 0, 1, 4'b0100, 2'd2);
    add(0, 4'b1111, 16'h1213, 0, 1, 4'b1000, 2'd3);
    add(0, 4'b1111, 16'h1213, 0, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 16'h1213, 0, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 16'h1213, 0, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 16'h1213, 0, 1, 4'b0010, 2'd1);
    // Equal weights: plain round robin
    add(1, 4'b1111, 16'h1111, 0, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 16'h1111, 0, 1, 4'b0010, 2'd1);
    add(0, 4'b1111, 16'h1111, 0, 1, 4'b0100, 2'd2);
    add(0, 4'b1111, 16'h1111, 0, 1, 4'b1000, 2'd3);
    add(0, 4'b1111, 16'h1111, 0, 1, 4'b0001, 2'd0);
    add(0, 4'b1111, 16'h1111, 0, 1, 4'b0010, 2'd1);
    // Zero weight disables requester 2
    add(1, 4'b0100, 16'h1011, 0, 0, 4'b0000, 2'd0);
    add(0, 4'b0100, 16'h1011, 0, 0, 4'b0000, 2'd0);
    add(0, 4'b0100, 16'h1011, 0, 0, 4'b0000, 2'd0);
    add(0, 4'b0110, 16'h1011, 0, 0, 4'b0010, 2'd1);
    add(0, 4'b0110, 16'h1011, 0, 1, 4'b0010, 2'd1);
    add(0, 4'b0110, 16'h1011, 0, 1, 4'b0010, 2'd1);
    // Hold without ack charges nothing; weight of id1 is 2
    add(1, 4'b0010, 16'h1121, 0, 0, 4'b0010, 2'd1);
    for (int k = 0; k < 5; k++) add(0, 4'b0110, 16'h1121, 0, 0, 4'b0010, 2'd1);
    add(0, 4'b0110, 16'h1121, 0, 1, 4'b0010, 2'd1);
    add(0, 4'b0110, 16'h1121, 0, 1, 4'b0100, 2'd2);
    add(0, 4'b0110, 16'h1121, 0, 1, 4'b0010, 2'd1);
    // Cancel: request 0 drops before ack, its credit must stay 2
    add(1, 4'b0011, 16'h2222, 0, 0, 4'b0001, 2'd0);
    add(0, 4'b0010, 16'h2222, 0, 0, 4'b0000, 2'd0);
    add(0, 4'b0010, 16'h2222, 0, 0, 4'b0010, 2'd1);
    add(0, 4'b0011, 16'h2222, 0, 1, 4'b0010, 2'd1);
    add(0, 4'b0011, 16'h2222, 0, 1, 4'b0001, 2'd0);
    add(0, 4'b0011, 16'h2222, 0, 1, 4'b0001, 2'd0);
    add(0, 4'b0011, 16'h2222, 0, 1, 4'b0010, 2'd1);
    // cfg_load overrides the simultaneous decrement
    add(1, 4'b0011, 16'h3333, 0, 0, 4'b0001, 2'd0);
    add(0, 4'b0011, 16'h1111, 1, 1, 4'b0001, 2'd0);
    add(0, 4'b0011, 16'h1111, 0, 1, 4'b0010, 2'd1);
    add(0, 4'b0011, 16'h1111, 0, 1, 4'b0001, 2'd0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      req = vecs[i].req; cfg_weight = vecs[i].wgt; cfg_load = vecs[i].load; ack = vecs[i].ack;
      @(posedge clk);
      #1;
      check_out($sformatf("row%0d", i), vecs[i].eg, vecs[i].eid);
    end

    // Asynchronous reset while grant=1000 with credits loaded
    do_reset();
    @(negedge clk);
    req = 4'b1000; cfg_weight = 16'h2222; cfg_load = 1'b0; ack = 1'b0;
    @(posedge clk);
    #1;
    check_out("pre_rst", 4'b1000, 2'd3);
    @(negedge clk);
    req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    check_out("async_rst", 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1; ack = 1'b1;
    seq_g  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100};
    seq_id = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("post_rst%0d", k), seq_g[k], seq_id[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
